// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble). Each clock adds 3 to any
// scratch digit >= 5 and then shifts one bit in. Results are held between conversions.
//
// state   | meaning
// S_IDLE  | waiting for start; bcd/overflow hold the last result (busy=0)
// S_SHIFT | one shift-and-add-3 iteration per clock, W iterations (busy=1)
module bin2bcd_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [W-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [W-1:0]    r_sr;
   logic [BW-1:0]   r_scr;
   logic [CW-1:0]   r_cnt;
   logic            r_ovf_acc;
   logic [BW-1:0]   r_bcd;
   logic            r_ovf;
   logic            r_done;

   logic            w_accept;
   logic            w_last;
   logic [BW-1:0]   w_corr;
   logic [BW-1:0]   w_scr_nxt;
   logic [W-1:0]    w_sr_nxt;
   logic            w_ovf_bit;

   always_comb begin
      w_corr = r_scr;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_scr[4*i +: 4] >= 4'd5) begin
            w_corr[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
         end
      end
   end

   // Corrected scratch and shift register move left as one word.
   assign w_scr_nxt = {w_corr[BW-2:0], r_sr[W-1]};
   assign w_sr_nxt  = r_sr << 1;
   assign w_ovf_bit = w_corr[BW-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Terminal count: this edge performs the W-th iteration.
            if (r_cnt == CW'(1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr      <= '0;
         r_scr     <= '0;
         r_cnt     <= '0;
         r_ovf_acc <= 1'b0;
         r_bcd     <= '0;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_sr      <= bin;
            r_scr     <= '0;
            r_cnt     <= CW'(W);
            r_ovf_acc <= 1'b0;
         end else if (r_state == S_SHIFT) begin
            r_sr      <= w_sr_nxt;
            r_scr     <= w_scr_nxt;
            r_cnt     <= r_cnt - CW'(1);
            r_ovf_acc <= r_ovf_acc | w_ovf_bit;
         end
         if (w_last) begin
            r_bcd <= w_scr_nxt;
            r_ovf <= r_ovf_acc | w_ovf_bit;
         end
      end
   end

   assign busy     = (r_state == S_SHIFT);
   assign done     = r_done;
   assign bcd      = r_bcd;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: two configurations checked every cycle against an
// arithmetic model (decimal digits via /10 and %10), plus literal spot checks.
module tb_bin2bcd_seq;

   localparam int WA = 16, DA = 5;
   localparam int WB = 10, DB = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic              a_start = 1'b0;
   logic [WA-1:0]     a_bin   = '0;
   logic              a_busy, a_done, a_ovf;
   logic [4*DA-1:0]   a_bcd;

   logic              b_start = 1'b0;
   logic [WB-1:0]     b_bin   = '0;
   logic              b_busy, b_done, b_ovf;
   logic [4*DB-1:0]   b_bcd;

   bin2bcd_seq #(.W(WA), .DIGITS(DA)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .bin(a_bin),
      .busy(a_busy), .done(a_done), .bcd(a_bcd), .overflow(a_ovf));

   bin2bcd_seq #(.W(WB), .DIGITS(DB)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .bin(b_bin),
      .busy(b_busy), .done(b_done), .bcd(b_bcd), .overflow(b_ovf));

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit          busy;
      int          cnt;
      bit          done;
      logic [39:0] bcd;
      bit          ovf;
      longint      bin;
   } m_t;

   m_t ma, mb;

   function automatic longint p10(int d);
      longint r = 1;
      for (int i = 0; i < d; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [39:0] bcd_of(longint v, int d);
      logic [39:0] r = '0;
      longint x = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic m_t m_reset();
      m_t m;
      m.busy = 0; m.cnt = 0; m.done = 0; m.bcd = '0; m.ovf = 0; m.bin = 0;
      return m;
   endfunction

   // One clock edge of the converter as observed from its ports.
   function automatic m_t m_step(m_t m, bit st, longint b, int w, int d);
      m_t n = m;
      n.done = 0;
      if (m.busy) begin
         n.cnt = m.cnt - 1;
         if (n.cnt == 0) begin
            n.busy = 0;
            n.done = 1;
            n.bcd  = bcd_of(m.bin, d);
            n.ovf  = (m.bin >= p10(d));
         end
      end else if (st) begin
         n.busy = 1;
         n.cnt  = w;
         n.bin  = b;
      end
      return n;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   initial begin
      ma = m_reset();
      mb = m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            ma = m_reset();
            mb = m_reset();
         end else begin
            ma = m_step(ma, a_start, longint'(a_bin), WA, DA);
            mb = m_step(mb, b_start, longint'(b_bin), WB, DB);
         end
         #1;
         chk("a_busy", a_busy, ma.busy);
         chk("a_done", a_done, ma.done);
         chk("a_bcd",  a_bcd,  longint'(ma.bcd[4*DA-1:0]));
         chk("a_ovf",  a_ovf,  ma.ovf);
         chk("b_busy", b_busy, mb.busy);
         chk("b_done", b_done, mb.done);
         chk("b_bcd",  b_bcd,  longint'(mb.bcd[4*DB-1:0]));
         chk("b_ovf",  b_ovf,  mb.ovf);
      end
   end

   task automatic start_a(input logic [WA-1:0] v);
      @(negedge clk);
      a_start = 1'b1;
      a_bin   = v;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   task automatic start_b(input logic [WB-1:0] v);
      @(negedge clk);
      b_start = 1'b1;
      b_bin   = v;
      @(negedge clk);
      b_start = 1'b0;
   endtask

   // Returns the number of negedges waited until done is seen (0 on timeout).
   task automatic wait_a(output int n);
      n = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (a_done) begin
            n = k + 1;
            break;
         end
      end
      chk("a_done_seen", (n != 0), 1);
   endtask

   task automatic wait_b(output int n);
      n = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (b_done) begin
            n = k + 1;
            break;
         end
      end
      chk("b_done_seen", (n != 0), 1);
   endtask

   task automatic count_a_done(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (a_done) n++;
      end
   endtask

   initial begin
      int n;
      logic [WB-1:0] b_edges [4];
      b_edges[0] = 10'd999; b_edges[1] = 10'd1000; b_edges[2] = 10'd1023; b_edges[3] = 10'd0;

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", a_busy, 0);
      chk("rst_bcd",  a_bcd, 0);
      rst_n = 1'b1;

      start_a(16'd0);
      wait_a(n);
      chk("lat_w", n, WA);
      chk("lit_0", a_bcd, 20'h00000);
      chk("lit_0_ovf", a_ovf, 0);

      start_a(16'd1234);
      @(negedge clk);
      chk("hold_busy", a_bcd, 20'h00000);
      wait_a(n);
      chk("lit_1234", a_bcd, 20'h01234);
      start_a(16'd65535);
      wait_a(n);
      chk("lit_65535", a_bcd, 20'h65535);
      chk("lit_65535_ovf", a_ovf, 0);
      @(negedge clk);
      chk("done_width", a_done, 0);

      start_a(16'd42);
      repeat (3) @(negedge clk);
      a_start = 1'b1;
      a_bin   = 16'd999;
      @(negedge clk);
      a_start = 1'b0;
      wait_a(n);
      chk("lit_42", a_bcd, 20'h00042);
      count_a_done(25, n);
      chk("no_second_done", n, 0);

      @(negedge clk);
      a_start = 1'b1;
      a_bin   = 16'd7;
      @(negedge clk);
      a_bin   = 16'd8;
      wait_a(n);
      chk("lit_7", a_bcd, 20'h00007);
      wait_a(n);
      a_start = 1'b0;
      chk("b2b_gap", n, WA + 1);
      chk("lit_8", a_bcd, 20'h00008);
      repeat (20) @(negedge clk);

      start_a(16'd5000);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", a_busy, 0);
      chk("abort_done", a_done, 0);
      chk("abort_bcd",  a_bcd, 0);
      chk("abort_ovf",  a_ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      count_a_done(25, n);
      chk("abort_no_done", n, 0);
      start_a(16'd5000);
      wait_a(n);
      chk("lit_5000", a_bcd, 20'h05000);

      start_b(10'd999);
      wait_b(n);
      chk("lit_b999", b_bcd, 12'h999);
      chk("lit_b999_ovf", b_ovf, 0);
      start_b(10'd1000);
      wait_b(n);
      chk("lit_b1000", b_bcd, 12'h000);
      chk("lit_b1000_ovf", b_ovf, 1);
      start_b(10'd1023);
      wait_b(n);
      chk("lit_b1023", b_bcd, 12'h023);
      chk("lit_b1023_ovf", b_ovf, 1);
      start_b(10'd5);
      wait_b(n);
      chk("lit_b5", b_bcd, 12'h005);
      chk("lit_b5_ovf", b_ovf, 0);

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         a_start = ($urandom_range(0, 2) == 0);
         a_bin   = WA'($urandom);
         b_start = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) b_bin = b_edges[$urandom_range(0, 3)];
         else                           b_bin = WB'($urandom);
      end
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
